// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and memory-side bus of the two-port memory arbiter
interface mem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rd;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rd;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd, m1_req, m1_we, m1_addr, m1_wd, mem_rd,
        output m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd, mem_we, mem_addr, mem_wd, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd, m1_req, m1_we, m1_addr, m1_wd, mem_rd,
        input  m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd, mem_we, mem_addr, mem_wd, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/load-store arbiter with region check and fixed read latency
module mem_arbiter #(
    parameter int          RD_LAT = 1,
    parameter logic [15:0] ROM_LO = 16'h0001,
    parameter logic [15:0] ROM_HI = 16'h000F,
    parameter logic [15:0] RAM_LO = 16'h0010,
    parameter logic [15:0] RAM_HI = 16'hFF0F
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT - 1);

    state_t      state;
    logic        last_grant;
    logic        gnt;
    logic [1:0]  cnt;
    logic        any;
    logic        pick;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic        is_rom;
    logic        is_ram;
    logic        bad;

    // arbitration choice and region/alignment decode of the candidate request
    always_comb begin
        any      = bus.m0_req | bus.m1_req;
        pick     = (bus.m0_req & bus.m1_req) ? ~last_grant : bus.m1_req;
        sel_we   = pick ? bus.m1_we : bus.m0_we;
        sel_addr = pick ? bus.m1_addr : bus.m0_addr;
        sel_wd   = pick ? bus.m1_wd : bus.m0_wd;
        is_rom   = (sel_addr[31:16] >= ROM_LO) && (sel_addr[31:16] <= ROM_HI);
        is_ram   = (sel_addr[31:16] >= RAM_LO) && (sel_addr[31:16] <= RAM_HI);
        bad      = (sel_addr[1:0] != 2'b00) || !(is_rom || is_ram) || (sel_we && is_rom);
    end

    // sequencer: grant in IDLE, hold the memory bus for RD_LAT cycles, pulse ack in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt          <= 1'b0;
            cnt          <= 2'd0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rd    <= 32'd0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rd    <= 32'd0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= 32'd0;
            bus.mem_wd   <= 32'd0;
            bus.busy     <= 1'b0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m0_err <= 1'b0;
            bus.m1_ack <= 1'b0;
            bus.m1_err <= 1'b0;
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        cnt        <= LAT;
                        bus.busy   <= 1'b1;
                        if (bad) begin
                            state <= DONE;
                            if (pick) begin
                                bus.m1_ack <= 1'b1;
                                bus.m1_err <= 1'b1;
                                bus.m1_rd  <= 32'd0;
                            end else begin
                                bus.m0_ack <= 1'b1;
                                bus.m0_err <= 1'b1;
                                bus.m0_rd  <= 32'd0;
                            end
                        end else begin
                            state        <= ACCESS;
                            bus.mem_we   <= sel_we;
                            bus.mem_addr <= sel_addr;
                            bus.mem_wd   <= sel_wd;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 2'd0) begin
                        state        <= DONE;
                        bus.mem_addr <= 32'd0;
                        bus.mem_wd   <= 32'd0;
                        if (gnt) begin
                            bus.m1_ack <= 1'b1;
                            bus.m1_rd  <= bus.mem_rd;
                        end else begin
                            bus.m0_ack <= 1'b1;
                            bus.m0_rd  <= bus.mem_rd;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port memory interface (ROM at 0x0001_0000–0x000F_FFFF, RAM at 0x0010_0000–0xFF0F_FFFF).
- Port m0 is instruction fetch; port m1 is load/store.
- Round-robin grant, fixed read latency, region/alignment check before issuing the access, one-cycle ack pulse with registered read data.

Parameters:
RD_LAT, 1, memory read latency in cycles (legal 1..4); length of ACCESS state
ROM_LO, 16'h0001, lowest addr[31:16] of ROM region
ROM_HI, 16'h000F, highest addr[31:16] of ROM region
RAM_LO, 16'h0010, lowest addr[31:16] of RAM region
RAM_HI, 16'hFF0F, highest addr[31:16] of RAM region

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
m0_req  input  1  fetch request, held until ack
m0_we  input  1  fetch write enable (normally 0)
m0_addr  input  32  fetch byte address
m0_wd  input  32  fetch write data
m0_ack  output  1  one-cycle completion pulse
m0_err  output  1  error flag, valid with m0_ack
m0_rd  output  32  read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_err, m1_rd  same as m0_* for load/store port
mem_we  output  1  write strobe to memory interface
mem_addr  output  32  address to memory interface
mem_wd  output  32  write data to memory interface
mem_rd  input  32  read data from memory interface
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE and last_grant goes to 1, so m0 wins the first tie. All outputs reset to 0: acks, errs, rd, mem_we, mem_addr, mem_wd, busy.
- Reset during ACCESS/DONE: the transaction is abandoned with no ack. mem_we is 0 from the next edge.
- States: IDLE, ACCESS, DONE.
- IDLE arbitration:
  - Only one req high: grant it.
  - Both high: grant the port that is not last_grant, then update last_grant to the granted port.
  - At the grant edge, latch we/addr/wd into internal registers and latch the grant index. Later changes on the requester fields are ignored.
- Decode at grant, on the latched address:
  - ROM region: reads only.
  - RAM region: reads and writes.
  - Error cases: addr[1:0] != 0, reserved region (any other addr[31:16]), or write to ROM.
- Error path: skip ACCESS and go IDLE -> DONE. err=1, rd=0, memory untouched (mem_we stays 0).
- ACCESS: lasts exactly RD_LAT cycles, tracked by a 2-bit down-counter.
  - mem_addr/mem_wd are driven from the latched registers for the whole state.
  - mem_we=1 only in the first ACCESS cycle and only for a valid RAM write.
  - On the last ACCESS cycle, register mem_rd into the granted port's rd (writes also capture it; value is don't-care to the requester).
- DONE: one cycle. Granted port's ack=1; err set as decoded. Next state IDLE.
- rd holds its value until that port's next ack. err is 0 whenever ack is 0.
- Latency, req sampled at edge T:
  - Valid access: ack at T+1+RD_LAT.
  - Error: ack at T+1.
  - Next grant no earlier than the IDLE cycle after DONE.
- Requester rules: hold req and fields stable until ack. In the cycle after ack, deassert req or present a new request.
- Dropping req after grant does not abort; ack still pulses.
- Outside ACCESS: mem_addr=0, mem_wd=0, mem_we=0.
- The non-granted port never sees ack.

Test Plan:
- Single read, RD_LAT=1: m1 reads 0x0010_0004 (RAM holds 0xDEADBEEF), req at T -> m1_ack=1 and m1_rd=0xDEADBEEF at T+2; mem_we stays 0; busy high T+1..T+2.
- Write then read: m1 writes 0x1234_5678 to 0x0010_0010 -> mem_we=1 exactly one cycle with mem_addr=0x0010_0010, ack at T+2, err=0; a following read of the same address returns 0x1234_5678.
- Contention: m0 and m1 both req from reset, held continuously -> grants alternate m0, m1, m0, m1; each ack arrives 3 cycles after the previous one; no port waits more than one transaction.
- Errors:
  - m1 write to 0x0001_0000 (ROM) -> m1_ack and m1_err=1 at T+1, mem_we never 1.
  - Read 0xFF20_0000 -> err=1, rd=0.
  - Read 0x0010_0002 -> err=1.
- RD_LAT=3: m0 reads ROM 0x0001_0000 -> ACCESS holds mem_addr for 3 cycles, m0_ack at T+4 with ROM word.
- Reset mid-ACCESS: assert rst on the cycle after the grant -> no ack on either port; next edge busy=0, mem_addr=0; after release, a tie is won by m0.
